// File: rtl/lc3_bus_arbiter.sv
// Round-robin 4-source bus arbiter for the LC-3 datapath with hold-time preemption.
// Optional LC3_BUS_TURNAROUND_EN inserts one dead GNT=0 cycle between owners.
module lc3_bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUS_BUSY
);

`ifdef LC3_BUS_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        busy_q;
  logic        release_w;
  logic [2:0]  pick_idle;
`ifndef LC3_BUS_TURNAROUND_EN
  logic [2:0]  pick_rel;
`endif

  // {found, index}: first set request scanning upward from ptr, wrapping 3->0
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    // gnt_q is the one-hot of owner_q while granting, so REQ & ~gnt_q are the waiters
    release_w = !REQ[owner_q] || ((hold_q == HOLD_MAX) && |(REQ & ~gnt_q));
    pick_idle = rr_pick(REQ, ptr_q);
`ifndef LC3_BUS_TURNAROUND_EN
    pick_rel  = rr_pick(REQ, owner_q + 2'd1);
`endif
    case (state_q)
      GRANT: begin
        if (release_w) begin
          ptr_d = owner_q + 2'd1;
`ifdef LC3_BUS_TURNAROUND_EN
          state_d = TURN;
          gnt_d   = 4'b0000;
`else
          if (pick_rel[2]) begin
            owner_d = pick_rel[1:0];
            hold_d  = 4'd0;
            gnt_d   = 4'b0001 << pick_rel[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
`endif
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          owner_d = pick_idle[1:0];
          hold_d  = 4'd0;
          gnt_d   = 4'b0001 << pick_idle[1:0];
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      busy_q  <= |gnt_d;
    end
  end

  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign BUS_BUSY = busy_q;

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Randomized + directed bench for lc3_bus_arbiter against a queue-free behavioural model.
// Build with or without LC3_BUS_TURNAROUND_EN to match the RTL.
module tb_lc3_bus_arbiter;
  localparam int MH = 4;
`ifdef LC3_BUS_TURNAROUND_EN
  localparam int PER = MH + 1;
`else
  localparam int PER = MH;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUS_BUSY;

  int npass = 0;
  int ntot  = 0;

  lc3_bus_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .GNT(GNT), .OWNER(OWNER), .BUS_BUSY(BUS_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: owner (-1 = bus free), rotating priority start, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_owner = -1; m_ptr = 0; m_hold = 0;
      end else if (m_owner >= 0) begin
        if (!REQ[m_owner] || (m_hold == MH - 1 && (REQ & ~(4'b1 << m_owner)) != 4'b0)) begin
          m_ptr = (m_owner + 1) % 4;
`ifdef LC3_BUS_TURNAROUND_EN
          m_owner = -1;
`else
          m_owner = rr(REQ, m_ptr);
`endif
          m_hold = 0;
        end else if (m_hold < MH - 1) begin
          m_hold++;
        end
      end else begin
        m_owner = rr(REQ, m_ptr);
        m_hold  = 0;
      end
    end
  end

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
  endfunction

  logic [3:0] prev_gnt = 4'b0;
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      check("model_gnt", GNT, m_gnt());
      check("busy_eq_or", BUS_BUSY, |GNT);
      if (m_owner >= 0) check("model_owner", OWNER, m_owner);
      check("onehot0", $onehot0(GNT), 1'b1);
`ifdef LC3_BUS_TURNAROUND_EN
      check("no_b2b_owners", (prev_gnt != 0 && GNT != 0 && prev_gnt != GNT), 1'b0);
`endif
      prev_gnt = GNT;
    end else begin
      prev_gnt = 4'b0;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    REQ = 4'b0; RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
  endtask

  initial begin
    REQ = 4'b0; RST_N = 1'b0;
    #3;
    check("rst_gnt", GNT, 4'b0);
    check("rst_busy", BUS_BUSY, 1'b0);
    check("rst_owner", OWNER, 2'd0);
    tick();
    RST_N = 1'b1;

    // first grant latency and handoff to the remaining requester
    tick();
    REQ = 4'b0101;
    tick();
    check("s1_first", GNT, 4'b0001);
    REQ = 4'b0100;
    tick();
`ifdef LC3_BUS_TURNAROUND_EN
    check("s1_turn", GNT, 4'b0000);
    tick();
`endif
    check("s1_second", GNT, 4'b0100);

    // all requesting: rotate 0,1,2,3,0 with MH cycles each
    do_reset();
    REQ = 4'b1111;
    tick();
    for (int c = 0; c < 5 * PER; c++) begin
      check("rr_seq", GNT, (c % PER == MH) ? 4'b0 : (4'b1 << ((c / PER) % 4)));
      tick();
    end

    // lone requester is never preempted
    do_reset();
    REQ = 4'b0100;
    tick();
    for (int c = 0; c < 20; c++) begin
      check("solo_gnt", GNT, 4'b0100);
      check("solo_busy", BUS_BUSY, 1'b1);
      check("solo_owner", OWNER, 2'd2);
      tick();
    end

    // async reset mid-grant
    #2 RST_N = 1'b0;
    #1;
    check("async_gnt", GNT, 4'b0);
    check("async_busy", BUS_BUSY, 1'b0);
    @(posedge CLK); #3;
    RST_N = 1'b1;
    REQ = 4'b1000;
    tick();
    check("post_rst_gnt", GNT, 4'b1000);

    // one-cycle pulse on bit1 while 3 owns the bus
    REQ = 4'b1010;
    tick();
    REQ = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("pulse_ignored", GNT, 4'b1000);
    end

    // fixed priority right after reset
    do_reset();
    REQ = 4'b1110;
    tick();
    check("post_rst_prio", GNT, 4'b0010);

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) REQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #2 RST_N = 1'b0;
        #4 RST_N = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/lc3_bus_arbiter.md
LC3_BUS_ARBITER -- requirements
Module: lc3_bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, cycles an owner may hold the bus while another requester waits (legal range 2..15).
REQ-002 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  asynchronous reset, active-low.
REQ-004 Port: REQ  input  4  bus requests; bit0 PC, bit1 MARMUX, bit2 ALU, bit3 MDR; level-held while the bus is wanted.
REQ-005 Port: GNT  output  4  registered one-hot or zero grant; each bit drives the SEL of that source's tristate bus driver.
REQ-006 Port: OWNER  output  2  binary index of the current grantee; meaningful only while BUS_BUSY=1.
REQ-007 Port: BUS_BUSY  output  1  high when any GNT bit is high.

Function
REQ-008 GNT shall never have more than one bit set in any cycle, including across handoffs.
REQ-009 States: IDLE (GNT=0), GRANT (GNT=one-hot of OWNER), TURN (GNT=0, one bus-turnaround cycle).
REQ-010 IDLE: if REQ!=0 at an edge, go to GRANT with the round-robin winner; first GNT visible the cycle after REQ is sampled (1-cycle latency).
REQ-011 Round-robin: search starts at index PTR and wraps 3->0; first set REQ bit wins.
REQ-012 On every release, PTR shall become (released OWNER+1) mod 4; PTR is otherwise unchanged.
REQ-013 GRANT: HOLD_CNT resets to 0 on grant and increments each cycle, saturating at MAX_HOLD-1.
REQ-014 GRANT release on an edge where REQ[OWNER]=0 (voluntary).
REQ-015 GRANT release on an edge where HOLD_CNT=MAX_HOLD-1 and any other REQ bit is set (preemption); with no other request pending, the grant continues indefinitely.
REQ-016 Voluntary drop and preemption on the same edge shall be treated as one release.
REQ-017 A preempted owner still holding REQ stays eligible but, per REQ-012, has lowest priority.
REQ-018 A REQ bit that deasserts before being sampled as winner shall not be granted; no request memory exists.
REQ-019 TURN: at the exit edge, if REQ!=0 go to GRANT with the round-robin winner, else go to IDLE.
REQ-020 BUS_BUSY shall equal the OR of GNT, registered, with no combinational path from REQ.

Reset
REQ-021 RST_N low shall immediately force GNT=0, OWNER=0, BUS_BUSY=0, state IDLE, PTR=0, HOLD_CNT=0, regardless of CLK.
REQ-022 Reset asserted mid-grant shall drop the grant in the same cycle; after release, the first grant follows REQ-010 with fixed priority 0>1>2>3.

Configuration
REQ-023 Macro LC3_BUS_TURNAROUND_EN defined: every release passes through TURN (one dead cycle with GNT=0) before the next grant.
REQ-024 Macro LC3_BUS_TURNAROUND_EN undefined: no TURN state exists; on release, the next winner is granted at the same edge (GNT switches one-hot to one-hot), or the arbiter goes to IDLE if REQ is otherwise zero.

Verification
REQ-025 Reset then REQ=4'b0101 held -> GNT=0001 one cycle after sampling; bit0 drops -> (TURN_EN: one GNT=0000 cycle) then GNT=0100.
REQ-026 MAX_HOLD=4, REQ=4'b1111 held -> grant order 0,1,2,3,0; each grant lasts 4 cycles; GNT never multi-hot.
REQ-027 MAX_HOLD=4, only REQ[2] held for 20 cycles -> GNT=0100 continuously, BUS_BUSY=1, OWNER=2.
REQ-028 RST_N pulsed low mid-grant asynchronous to CLK -> GNT=0000 and BUS_BUSY=0 before the next edge; after release, REQ=4'b1000 -> GNT=1000 with 1-cycle latency.
REQ-029 One-cycle REQ[1] pulse while owner 3 holds the bus -> REQ[1] never granted; owner 3 unaffected.
REQ-030 Both macro settings: random REQ for 10k cycles -> onehot0(GNT) every cycle; BUS_BUSY==|GNT; with TURN_EN, no back-to-back different owners.
